// File: rtl/uncached_axi_bridge_pkg.sv
// uncached_axi_bridge_pkg: shared FSM states, size codes, constant AXI fields and write-strobe helper.
package uncached_axi_bridge_pkg;
    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP} state_t;
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;
    localparam logic [3:0] AXI_ID = 4'd0;
    localparam logic [3:0] AXI_LEN = 4'd0;
    localparam logic [1:0] AXI_BURST = 2'b01;
    localparam logic [1:0] AXI_LOCK = 2'b00;
    localparam logic [3:0] AXI_CACHE = 4'd0;
    localparam logic [2:0] AXI_PROT = 3'd0;
    // size 3 falls through to a full-word strobe
    function automatic logic [3:0] wstrb_gen(input logic [1:0] size, input logic [1:0] off);
        return size == SIZE_BYTE ? 4'b0001 << off : size == SIZE_HALF ? 4'b0011 << {off[1], 1'b0} : 4'b1111;
    endfunction
endpackage

// File: rtl/uncached_axi_bridge_if.sv
// uncached_axi_bridge_if: single-beat AXI3 master bus between the uncached bridge and the interconnect.
interface uncached_axi_bridge_if;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic        arvalid, arready;
    logic [3:0]  arid, arlen, arcache;
    logic [1:0]  arburst, arlock;
    logic [2:0]  arprot;
    logic [31:0] rdata;
    logic        rvalid, rready;
    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic        awvalid, awready;
    logic [3:0]  awid, awlen, awcache;
    logic [1:0]  awburst, awlock;
    logic [2:0]  awprot;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid, wready, wlast;
    logic        bvalid, bready;
    modport master(
        output araddr, arsize, arvalid, arid, arlen, arcache, arburst, arlock, arprot, rready,
        output awaddr, awsize, awvalid, awid, awlen, awcache, awburst, awlock, awprot,
        output wid, wdata, wstrb, wvalid, wlast, bready,
        input  arready, rdata, rvalid, awready, wready, bvalid
    );
    modport slave(
        input  araddr, arsize, arvalid, arid, arlen, arcache, arburst, arlock, arprot, rready,
        input  awaddr, awsize, awvalid, awid, awlen, awcache, awburst, awlock, awprot,
        input  wid, wdata, wstrb, wvalid, wlast, bready,
        output arready, rdata, rvalid, awready, wready, bvalid
    );
endinterface

// File: rtl/uncached_axi_bridge_write_channel.sv
// uncached_axi_bridge_write_channel: AW/W/B sequencing for one single-beat write.
module uncached_axi_bridge_write_channel
    import uncached_axi_bridge_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic awready,
    input  logic wready,
    input  logic bvalid,
    output logic awvalid,
    output logic wvalid,
    output logic bready,
    output logic busy,
    output logic done
);
    state_t state, state_n;
    logic aw_n, w_n;
    // AW and W rise together and each falls on its own handshake
    always_comb begin
        aw_n = state == IDLE ? start : awvalid & ~awready;
        w_n = state == IDLE ? start : wvalid & ~wready;
        state_n = state;
        case (state)
            IDLE:    state_n = start ? WR_REQ : IDLE;
            WR_REQ:  state_n = aw_n | w_n ? WR_REQ : WR_RESP;
            WR_RESP: state_n = bvalid ? IDLE : WR_RESP;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            awvalid <= 1'b0;
            wvalid <= 1'b0;
        end else begin
            state <= state_n;
            awvalid <= aw_n;
            wvalid <= w_n;
        end
    end
    assign bready = state == WR_RESP;
    assign busy = state != IDLE;
    assign done = bready & bvalid;
endmodule

// File: rtl/uncached_axi_bridge.sv
// uncached_axi_bridge: sram-like uncached data request to single-beat AXI3 read/write.
// UNCACHED_WBUF_EN: posted one-entry write buffer (write data_ok at cycle 1, drain in background).
module uncached_axi_bridge
    import uncached_axi_bridge_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    uncached_axi_bridge_if.master axi
);
    state_t state, state_n;
    logic [31:0] addr_q, wdata_q;
    logic [1:0] size_q;
    logic wc_busy, wc_done, wr_ok, rd_ok;
`ifdef UNCACHED_WBUF_EN
    localparam state_t WR_NEXT = IDLE;
    assign wr_ok = data_addr_ok & data_wr;
`else
    localparam state_t WR_NEXT = WR_REQ;
    assign wr_ok = wc_done;
`endif
    // a draining write blocks every new request so reads stay ordered behind it
    assign data_addr_ok = data_req & (state == IDLE) & ~wc_busy;
    assign rd_ok = (state == RD_DATA) & axi.rvalid;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = data_addr_ok ? (data_wr ? WR_NEXT : RD_ADDR) : IDLE;
            RD_ADDR: state_n = axi.arready ? RD_DATA : RD_ADDR;
            RD_DATA: state_n = axi.rvalid ? IDLE : RD_DATA;
            default: state_n = wc_done ? IDLE : state;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            addr_q <= '0;
            size_q <= '0;
            wdata_q <= '0;
            data_data_ok <= 1'b0;
            data_rdata <= '0;
        end else begin
            state <= state_n;
            data_data_ok <= rd_ok | wr_ok;
            if (rd_ok) data_rdata <= axi.rdata;
            if (data_addr_ok) begin
                addr_q <= data_addr;
                size_q <= data_size;
                wdata_q <= data_wdata;
            end
        end
    end
    uncached_axi_bridge_write_channel u_wc (
        .clk(clk),
        .rst(rst),
        .start(data_addr_ok & data_wr),
        .awready(axi.awready),
        .wready(axi.wready),
        .bvalid(axi.bvalid),
        .awvalid(axi.awvalid),
        .wvalid(axi.wvalid),
        .bready(axi.bready),
        .busy(wc_busy),
        .done(wc_done)
    );
    assign axi.araddr = addr_q;
    assign axi.arsize = {1'b0, size_q};
    assign axi.arvalid = state == RD_ADDR;
    assign axi.rready = state == RD_DATA;
    assign axi.awaddr = addr_q;
    assign axi.awsize = {1'b0, size_q};
    assign axi.wdata = wdata_q;
    assign axi.wstrb = wstrb_gen(size_q, addr_q[1:0]);
    assign axi.wlast = 1'b1;
    assign axi.arid = AXI_ID;
    assign axi.arlen = AXI_LEN;
    assign axi.arburst = AXI_BURST;
    assign axi.arlock = AXI_LOCK;
    assign axi.arcache = AXI_CACHE;
    assign axi.arprot = AXI_PROT;
    assign axi.awid = AXI_ID;
    assign axi.awlen = AXI_LEN;
    assign axi.awburst = AXI_BURST;
    assign axi.awlock = AXI_LOCK;
    assign axi.awcache = AXI_CACHE;
    assign axi.awprot = AXI_PROT;
    assign axi.wid = AXI_ID;
endmodule
